cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15: maximum FETCH wait cycles for imem_ack before FAULT (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port run  input  1  level; 1 permits instruction issue from IDLE and WB.
REQ-005 SHALL have port imem_ack  input  1  instruction memory response valid for the current request.
REQ-006 SHALL have port instr  input  16  instruction word; sampled only when imem_req and imem_ack are both 1.
REQ-007 SHALL have port imem_req  output  1  instruction fetch request.
REQ-008 SHALL have port ir_load  output  1  instruction register load strobe.
REQ-009 SHALL have port alu_op  output  2  ALU operation select.
REQ-010 SHALL have port rf_we  output  1  register file write enable.
REQ-011 SHALL have port pc_en  output  1  program counter advance strobe.
REQ-012 SHALL have port state  output  3  current FSM state code.
REQ-013 SHALL have port halted  output  1  1 in HALT.
REQ-014 SHALL have port fault  output  1  1 in FAULT.
REQ-015 SHALL have port instr_count  output  16  count of retired instructions.

Function
REQ-016 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, FAULT=6; code 7 SHALL go to FAULT on the next edge.
REQ-017 IDLE: run=1 -> FETCH next cycle; otherwise stay in IDLE.
REQ-018 FETCH: imem_req=1 throughout; on imem_ack=1: ir_load=1 that cycle, latch instr[15:12] as opcode, -> DECODE.
REQ-019 FETCH: wait counter starts at 0 on entry and increments each cycle without ack; ack absent for ACK_TIMEOUT consecutive cycles -> FAULT. Ack in the cycle the counter reaches ACK_TIMEOUT-1 is still accepted.
REQ-020 DECODE (1 cycle): opcode 4'hF -> HALT; any other opcode -> EXEC.
REQ-021 Opcode map: 0x1 ADD alu_op=00; 0x2 SUB alu_op=01; 0x3 AND alu_op=10; 0x4 OR alu_op=11. These opcodes are writing ops. All other opcodes except 0xF are NOPs: alu_op=00, no register write.
REQ-022 alu_op SHALL be driven from the latched opcode in EXEC and WB; it SHALL be 00 in all other states.
REQ-023 EXEC (1 cycle) -> WB.
REQ-024 WB (1 cycle): rf_we=1 for writing ops only; pc_en=1; instr_count increments, wrapping 0xFFFF -> 0x0000. Then run=1 -> FETCH, run=0 -> IDLE.
REQ-025 Instruction latency: exactly 4 cycles from ack to the next imem_req when run stays 1 (DECODE, EXEC, WB, FETCH).
REQ-026 HALT: halted=1; no strobes; pc_en=0; instr_count not incremented; leave only by reset.
REQ-027 FAULT: fault=1; all strobes 0; leave only by reset.
REQ-028 imem_req, ir_load, rf_we and pc_en SHALL be mutually consistent: at most one of ir_load, rf_we|pc_en is active in any cycle.
REQ-029 run deasserting mid-instruction SHALL NOT abort it; it takes effect only at WB or IDLE.
REQ-030 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-031 rst=0 SHALL immediately force: state=IDLE, imem_req=0, ir_load=0, rf_we=0, pc_en=0, alu_op=00, halted=0, fault=0, instr_count=0, opcode latch=0, wait counter=0.
REQ-032 Reset asserted mid-instruction SHALL discard it with no rf_we or pc_en pulse; the first edge after release evaluates IDLE.

Configuration
REQ-033 Macro CPU_SEQ_SINGLE_STEP_EN defined: adds input step (1 bit). IDLE -> FETCH requires run=1 AND step=1 in the same cycle. WB always -> IDLE. Each step pulse therefore retires exactly one instruction.
REQ-034 Macro undefined: no step port; behaviour per REQ-017 and REQ-024.

Verification
REQ-035 Reset, then run=1, ack on the 1st FETCH cycle, instr=0x1xxx -> ir_load at cycle 1; rf_we=1, pc_en=1, alu_op=00 at cycle 4; instr_count=1.
REQ-036 Sequence 0x2..., 0x0..., 0x4... with immediate acks -> alu_op 01/00/11 in the EXEC and WB cycles; rf_we pulses 1/0/1; instr_count=3; imem_req every 4 cycles.
REQ-037 ACK_TIMEOUT=15, no ack -> FAULT entered after 15 FETCH cycles, fault=1; ack on the 15th FETCH cycle -> DECODE instead.
REQ-038 instr=0xF000 -> HALT after DECODE, halted=1, no pc_en; instr_count unchanged; run toggling has no effect until rst pulse.
REQ-039 rst=0 asserted during EXEC -> all outputs reset asynchronously, with no rf_we in WB; instr_count preloaded to 0xFFFF after one retire -> wraps to 0x0000.
REQ-040 With CPU_SEQ_SINGLE_STEP_EN defined: run=1, three step pulses -> exactly three WB cycles, and the FSM returns to IDLE after each one.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC -> WB, with HALT and FAULT sinks.
// Optional macro CPU_SEQ_SINGLE_STEP_EN adds a step input so each step pulse retires one instruction.
module cpu_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic        imem_ack,
    input  logic [15:0] instr,
    output logic        imem_req,
    output logic        ir_load,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic        pc_en,
    output logic [2:0]  state,
    output logic        halted,
    output logic        fault,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [7:0] WAIT_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [3:0] OP_HALT    = 4'hF;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [15:0] count_q, count_d;
    logic        start_ok;
    logic        wb_to_fetch;
    logic        op_writes;
    logic [1:0]  op_alu;
    logic        instr_unused;

    // Only the opcode nibble is consumed; operand fields belong to the datapath.
    assign instr_unused = ^instr[11:0];

`ifdef CPU_SEQ_SINGLE_STEP_EN
    assign start_ok    = run & step;
    assign wb_to_fetch = 1'b0;
`else
    assign start_ok    = run;
    assign wb_to_fetch = run;
`endif

    always_comb begin
        op_writes = 1'b0;
        op_alu    = 2'b00;
        case (opcode_q)
            4'h1: begin op_writes = 1'b1; op_alu = 2'b00; end
            4'h2: begin op_writes = 1'b1; op_alu = 2'b01; end
            4'h3: begin op_writes = 1'b1; op_alu = 2'b10; end
            4'h4: begin op_writes = 1'b1; op_alu = 2'b11; end
            default: begin op_writes = 1'b0; op_alu = 2'b00; end
        endcase
    end

    // Outputs decode purely from the registered state, so reset clears them without waiting for a clock.
    always_comb begin
        state_d  = state_q;
        wait_d   = 8'd0;
        opcode_d = opcode_q;
        count_d  = count_q;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        alu_op   = 2'b00;
        rf_we    = 1'b0;
        pc_en    = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load  = 1'b1;
                    opcode_d = instr[15:12];
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_d = (opcode_q == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_op  = op_alu;
                state_d = S_WB;
            end
            S_WB: begin
                alu_op  = op_alu;
                rf_we   = op_writes;
                pc_en   = 1'b1;
                count_d = count_q + 16'd1;
                state_d = wb_to_fetch ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wait_q   <= 8'd0;
            opcode_q <= 4'h0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule
